// File: rtl/lod_norm_pipe_if.sv
// Stream interface for the leading-one detector / normaliser.
// The master side supplies operands and accepts results; the slave side is the pipeline.
interface lod_norm_pipe_if #(
    parameter int WIDTH = 24,
    parameter int OUT_W = 5,
    parameter int TAG_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_pos;
    logic [OUT_W-1:0] out_lzc;
    logic             out_zero;
    logic [WIDTH-1:0] out_norm;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_pos, out_lzc, out_zero, out_norm, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_pos, out_lzc, out_zero, out_norm, out_tag
    );
endinterface

// File: rtl/lod_norm_pipe.sv
// Two-stage pipelined leading-one detector and left normaliser.
// Stage 1 finds the highest set bit (prefix-OR + one-hot encode), stage 2 shifts
// the operand left by the leading-zero count. Full valid/ready backpressure.
module lod_norm_pipe #(
    parameter int WIDTH = 24,
    parameter int OUT_W = 5,
    parameter int TAG_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    lod_norm_pipe_if.slave  bus
);

    // pipeline state
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s1_data_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [OUT_W-1:0] s1_pos_q;
    logic [OUT_W-1:0] s1_lzc_q;
    logic             s1_zero_q;
    logic [WIDTH-1:0] s2_norm_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [OUT_W-1:0] s2_pos_q;
    logic [OUT_W-1:0] s2_lzc_q;
    logic             s2_zero_q;

    // combinational helpers
    logic             s1_en_s;
    logic             s2_en_s;
    logic [WIDTH-1:0] pre_s;
    logic [WIDTH-1:0] oh_s;
    logic [OUT_W-1:0] pos_s;
    logic [OUT_W-1:0] lzc_s;
    logic             zero_s;
    logic [WIDTH-1:0] norm_s;

    // Advance enables: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_en_s    = !s2_valid_q || bus.out_ready;
        s1_en_s    = !s1_valid_q || s2_en_s;
        s2_valid_d = s2_en_s ? s1_valid_q : s2_valid_q;
        s1_valid_d = s1_en_s ? bus.in_valid : s1_valid_q;
    end

    // Leading-one detect: prefix-OR from the MSB down, isolate the top one, encode its index.
    always_comb begin
        pre_s = '0;
        pos_s = '0;
        pre_s[WIDTH-1] = bus.in_data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            pre_s[i] = pre_s[i+1] | bus.in_data[i];
        end
        oh_s = pre_s & ~(pre_s >> 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (oh_s[i]) begin
                pos_s = pos_s | OUT_W'(i);
            end else begin
                pos_s = pos_s;
            end
        end
        zero_s = ~pre_s[0];
        lzc_s  = zero_s ? OUT_W'(WIDTH) : (OUT_W'(WIDTH - 1) - pos_s);
    end

    // Normalising shift on the stage-1 operand; a zero operand shifts to zero.
    always_comb begin
        norm_s = s1_data_q << s1_lzc_q;
    end

    // Valid bits for both stages; reset flushes anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // Stage 1 data: capture operand and detect results on acceptance, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q <= '0;
            s1_tag_q  <= '0;
            s1_pos_q  <= '0;
            s1_lzc_q  <= '0;
            s1_zero_q <= 1'b0;
        end else if (s1_en_s && bus.in_valid) begin
            s1_data_q <= bus.in_data;
            s1_tag_q  <= bus.in_tag;
            s1_pos_q  <= pos_s;
            s1_lzc_q  <= lzc_s;
            s1_zero_q <= zero_s;
        end
    end

    // Stage 2 data: take the shifted operand when stage 1 advances a valid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_norm_q <= '0;
            s2_tag_q  <= '0;
            s2_pos_q  <= '0;
            s2_lzc_q  <= '0;
            s2_zero_q <= 1'b0;
        end else if (s2_en_s && s1_valid_q) begin
            s2_norm_q <= norm_s;
            s2_tag_q  <= s1_tag_q;
            s2_pos_q  <= s1_pos_q;
            s2_lzc_q  <= s1_lzc_q;
            s2_zero_q <= s1_zero_q;
        end
    end

    assign bus.in_ready  = s1_en_s;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_pos   = s2_pos_q;
    assign bus.out_lzc   = s2_lzc_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_norm  = s2_norm_q;
    assign bus.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lod_norm_pipe.sv
// Bench for lod_norm_pipe: directed cases with literal expectations plus a random
// stream checked against a queue-based reference model. A second WIDTH=53 build is
// exercised with a few directed operands.
module tb_lod_norm_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lod_norm_pipe_if #(.WIDTH(24), .OUT_W(5), .TAG_W(10)) bus ();
    lod_norm_pipe_if #(.WIDTH(53), .OUT_W(6), .TAG_W(4))  b53 ();

    lod_norm_pipe #(.WIDTH(24), .OUT_W(5), .TAG_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    lod_norm_pipe #(.WIDTH(53), .OUT_W(6), .TAG_W(4)) dut53 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b53)
    );

    typedef struct {
        int          pos;
        int          lzc;
        logic        zero;
        logic [63:0] norm;
        logic [63:0] tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: scan for the highest set bit, then shift with plain arithmetic.
    function automatic exp_t model(input logic [63:0] d, input logic [63:0] tag, input int w);
        exp_t        e;
        logic [63:0] mask;
        mask   = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        d      = d & mask;
        e.pos  = 0;
        e.zero = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (d[i]) begin
                e.pos  = i;
                e.zero = 1'b0;
            end
        end
        e.lzc  = e.zero ? w : (w - 1 - e.pos);
        e.norm = (d << e.lzc) & mask;
        e.tag  = tag;
        return e;
    endfunction

    // One cycle: drive at the falling edge, then compare outputs and log handshakes.
    task automatic step(input logic v, input logic [23:0] d, input logic [9:0] t,
                        input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_tag    = t;
        bus.out_ready = ordy;
        #1;
        if (q.size() == 0) begin
            chk("no_spurious_valid", {63'd0, bus.out_valid}, 64'd0);
        end else if (bus.out_valid) begin
            e = q[0];
            chk("pos",  {59'd0, bus.out_pos}, 64'(e.pos));
            chk("lzc",  {59'd0, bus.out_lzc}, 64'(e.lzc));
            chk("zero", {63'd0, bus.out_zero}, {63'd0, e.zero});
            chk("norm", {40'd0, bus.out_norm}, e.norm);
            chk("tag",  {54'd0, bus.out_tag}, e.tag);
            if (ordy) begin
                e = q.pop_front();
            end
        end
        acc = v & bus.in_ready;
        if (acc) begin
            q.push_back(model({40'd0, d}, {54'd0, t}, 24));
        end
    endtask

    function automatic logic [23:0] rand_data();
        logic [23:0] x;
        x = 24'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            x = 24'd0;
        end else begin
            x = x >> $urandom_range(0, 23);
        end
        return x;
    endfunction

    // Drive one operand into the 53-bit build and check it two edges later.
    task automatic run53(input logic [52:0] d, input int epos, input int elzc, input logic ezero,
                         input logic [52:0] enorm);
        exp_t e;
        e = model({11'd0, d}, 64'h5, 53);
        @(negedge clk);
        b53.in_valid = 1'b1;
        b53.in_data  = d;
        b53.in_tag   = 4'h5;
        @(negedge clk);
        b53.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("w53_valid", {63'd0, b53.out_valid}, 64'd1);
        chk("w53_pos",   {58'd0, b53.out_pos}, 64'(epos));
        chk("w53_lzc",   {58'd0, b53.out_lzc}, 64'(elzc));
        chk("w53_zero",  {63'd0, b53.out_zero}, {63'd0, ezero});
        chk("w53_norm",  {11'd0, b53.out_norm}, {11'd0, enorm});
        chk("w53_model_pos", {58'd0, b53.out_pos}, 64'(e.pos));
        chk("w53_model_norm", {11'd0, b53.out_norm}, e.norm);
        chk("w53_tag",   {60'd0, b53.out_tag}, 64'h5);
    endtask

    initial begin
        logic        a;
        int          acc_n;
        int          cyc;
        logic        rv;
        logic [23:0] rd;
        logic [9:0]  rt;

        bus.in_valid  = 1'b0;
        bus.in_data   = 24'd0;
        bus.in_tag    = 10'd0;
        bus.out_ready = 1'b1;
        b53.in_valid  = 1'b0;
        b53.in_data   = 53'd0;
        b53.in_tag    = 4'd0;
        b53.out_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // reset state
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        chk("rst_pos",       {59'd0, bus.out_pos}, 64'd0);
        chk("rst_lzc",       {59'd0, bus.out_lzc}, 64'd0);
        chk("rst_zero",      {63'd0, bus.out_zero}, 64'd0);
        chk("rst_norm",      {40'd0, bus.out_norm}, 64'd0);
        chk("rst_tag",       {54'd0, bus.out_tag}, 64'd0);

        // single LSB operand, latency two edges
        step(1'b1, 24'h000001, 10'h155, 1'b1, a);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        chk("t1_not_early", {63'd0, bus.out_valid}, 64'd0);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        chk("t1_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t1_pos",   {59'd0, bus.out_pos}, 64'd0);
        chk("t1_lzc",   {59'd0, bus.out_lzc}, 64'd23);
        chk("t1_norm",  {40'd0, bus.out_norm}, 64'h800000);
        chk("t1_zero",  {63'd0, bus.out_zero}, 64'd0);
        chk("t1_tag",   {54'd0, bus.out_tag}, 64'h155);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);

        // back-to-back: MSB set, mid pattern, zero
        step(1'b1, 24'h800000, 10'h001, 1'b1, a);
        step(1'b1, 24'h00F0F0, 10'h002, 1'b1, a);
        step(1'b1, 24'h000000, 10'h003, 1'b1, a);
        chk("b2b0_pos",  {59'd0, bus.out_pos}, 64'd23);
        chk("b2b0_lzc",  {59'd0, bus.out_lzc}, 64'd0);
        chk("b2b0_norm", {40'd0, bus.out_norm}, 64'h800000);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        chk("b2b1_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("b2b1_pos",  {59'd0, bus.out_pos}, 64'd15);
        chk("b2b1_lzc",  {59'd0, bus.out_lzc}, 64'd8);
        chk("b2b1_norm", {40'd0, bus.out_norm}, 64'hF0F000);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        chk("b2b2_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("b2b2_zero", {63'd0, bus.out_zero}, 64'd1);
        chk("b2b2_pos",  {59'd0, bus.out_pos}, 64'd0);
        chk("b2b2_lzc",  {59'd0, bus.out_lzc}, 64'd24);
        chk("b2b2_norm", {40'd0, bus.out_norm}, 64'd0);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);

        // backpressure: two accepts fill the pipe, then in_ready drops
        acc_n = 0;
        step(1'b1, 24'h400000, 10'h010, 1'b0, a); acc_n += int'(a);
        step(1'b1, 24'h200000, 10'h011, 1'b0, a); acc_n += int'(a);
        step(1'b1, 24'h100000, 10'h012, 1'b0, a); acc_n += int'(a);
        chk("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_hold_pos", {59'd0, bus.out_pos}, 64'd22);
        step(1'b1, 24'h100000, 10'h012, 1'b0, a); acc_n += int'(a);
        chk("bp_accepts", 64'(acc_n), 64'd2);
        chk("bp_stable_pos", {59'd0, bus.out_pos}, 64'd22);
        chk("bp_stable_norm", {40'd0, bus.out_norm}, 64'h800000);
        step(1'b1, 24'h100000, 10'h012, 1'b1, a);
        chk("bp_rel_accept", {63'd0, a}, 64'd1);
        chk("bp_rel0_pos", {59'd0, bus.out_pos}, 64'd22);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        chk("bp_rel1_pos", {59'd0, bus.out_pos}, 64'd21);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        chk("bp_rel2_pos", {59'd0, bus.out_pos}, 64'd20);
        step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // random stream with random valid/ready and tags
        acc_n = 0;
        cyc   = 0;
        rv    = 1'b0;
        rd    = 24'd0;
        rt    = 10'd0;
        while (acc_n < 10000 && cyc < 40000) begin
            if (!rv) begin
                rv = ($urandom_range(0, 9) < 7);
                rd = rand_data();
                rt = 10'($urandom);
            end
            step(rv, rd, rt, ($urandom_range(0, 9) < 7), a);
            cyc++;
            if (a) begin
                acc_n++;
                rv = 1'b0;
            end
        end
        chk("random_accepted", 64'(acc_n), 64'd10000);
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            step(1'b0, 24'h000000, 10'h000, 1'b1, a);
        end
        chk("random_drained", 64'(q.size()), 64'd0);

        // reset mid-stream with two operands in flight
        step(1'b1, 24'h000300, 10'h0AA, 1'b1, a);
        step(1'b1, 24'h004000, 10'h0BB, 1'b1, a);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("mrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mrst_pos",  {59'd0, bus.out_pos}, 64'd0);
        chk("mrst_lzc",  {59'd0, bus.out_lzc}, 64'd0);
        chk("mrst_norm", {40'd0, bus.out_norm}, 64'd0);
        chk("mrst_tag",  {54'd0, bus.out_tag}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 24'h000000, 10'h000, 1'b1, a);
            chk("mrst_no_stale", {63'd0, bus.out_valid}, 64'd0);
        end

        // 53-bit build boundaries
        run53(53'd1 << 52, 52, 0, 1'b0, 53'd1 << 52);
        run53(53'd1, 0, 52, 1'b0, 53'd1 << 52);
        run53(53'd0, 0, 53, 1'b1, 53'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lod_norm_pipe.md
Name: lod_norm_pipe

Overview:
- Parametrised, pipelined leading-one detector and normaliser for the FP datapath (Nroot Taylor path, mantissa renormalisation after subtract/multiply).
- Finds the highest set bit of a WIDTH-bit operand and returns its bit index, the leading-zero count, a zero flag and the left-normalised operand.
- Two register stages with valid/ready flow control and full backpressure. A sideband tag (e.g. sign/exponent) travels alongside each operand.

Parameters:
- WIDTH, 24, operand width in bits (2..64).
- OUT_W, 5, width of pos/lzc outputs; must satisfy 2^OUT_W > WIDTH.
- TAG_W, 10, width of the sideband tag carried with each operand.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_pos  output  OUT_W  bit index of highest set bit (0 when zero).
- out_lzc  output  OUT_W  leading-zero count = WIDTH-1-pos; WIDTH when zero.
- out_zero  output  1  operand was all zeros.
- out_norm  output  WIDTH  in_data << lzc; all zeros when zero.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: s1_valid=0, s2_valid=0, out_valid=0. All data registers cleared: out_pos=0, out_lzc=0, out_zero=0, out_norm=0, out_tag=0. in_ready=1 on the first edge after reset release.
- Stage 1 (detect): registers in_data, in_tag, pos, zero and lzc.
  - pos and lzc come from a generic prefix-OR / one-hot priority encode over WIDTH bits. There are no hard-coded bit positions.
- Stage 2 (shift): registers norm = s1_data << s1_lzc (WIDTH bits, overflow discarded), plus the pos/lzc/zero/tag forwarded from stage 1.
- Stage 2 registers drive the outputs directly; no combinational path from in_data to any out_* port.
- Latency: 2 cycles from accepted input (in_valid & in_ready at edge N) to out_valid at edge N+2, when out_ready is held high.
- Throughput: 1 operand/cycle under continuous out_ready=1.
- Advance rules:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en. This is combinational from out_ready; the path is accepted.
- Transfer: an operand is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Stall: while out_valid & !out_ready, all out_* hold stable. Both stages hold their contents, and no operand is dropped or duplicated.
- Bubbles: an empty stage fills even while downstream is stalled. Pipeline holds at most 2 operands.
- Simultaneous events: in the same cycle, consume at the output, advance s1 to s2, and accept a new operand at s1.
- Zero operand: out_zero=1, out_pos=0, out_lzc=WIDTH, out_norm=0.
- MSB set: out_lzc=0, out_norm=in_data.
- Reset mid-operation: asserting rst_n low discards all in-flight operands immediately (asynchronous). No result appears for them after reset release.
- Data registers of an invalid stage hold their previous values; the bench checks data only when the stage's valid is high.

Test Plan:
- WIDTH=24, out_ready=1; in_data=0x000001 -> 2 cycles later out_pos=0, out_lzc=23, out_norm=0x800000, out_zero=0.
- in_data=0x800000, then 0x00F0F0, then 0x000000, back-to-back -> results on 3 consecutive cycles:
  - pos=23/lzc=0/norm=0x800000;
  - pos=15/lzc=8/norm=0xF0F000;
  - zero=1/pos=0/lzc=24/norm=0x000000.
- Backpressure: out_ready=0 with in_valid=1 continuously (operands 0x400000, 0x200000, 0x100000) -> in_ready drops after 2 accepts and out_* stable at pos=22.
  - Release out_ready -> outputs pos 22, 21, 20 in order, none lost or duplicated.
- Random stream of 10k operands with random in_valid/out_ready and random tags -> every result matches the reference model (pos, lzc, zero, norm) in order, with tag preserved.
- Reset mid-stream: 2 operands in flight, pulse rst_n low for 1 cycle between edges -> out_valid=0 immediately, all outputs 0, and no stale result emitted after release.
- WIDTH=53, OUT_W=6 build: in_data=1<<52 -> lzc=0; in_data=1 -> pos=0, lzc=52; in_data=0 -> lzc=53.
